// File: rtl/mem16x10_pkg.sv
// Shared widths and port identifiers for the two-port arbiter onto a 1024x16 single-port RAM.
package mem16x10_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/arb2_pick.sv
// Pure combinational grant decision between the two requesters.
module arb2_pick
    import mem16x10_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              req0_i,
    input  logic              req1_i,
    input  port_id_t          last_gnt_i,
    input  logic [WAIT_W-1:0] wait_cnt_i,
    output logic              gnt0_o,
    output logic              gnt1_o
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (req0_i && req1_i) begin
            if (PRIO_MODE == 1) begin
                // Port 0 wins unless port 1 has waited its full budget.
                if (wait_cnt_i == MAX_WAIT_C) begin
                    gnt1_o = 1'b1;
                end else begin
                    gnt0_o = 1'b1;
                end
            end else begin
                if (last_gnt_i == PORT0) begin
                    gnt1_o = 1'b1;
                end else begin
                    gnt0_o = 1'b1;
                end
            end
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end
    end

endmodule

// File: rtl/mem16x10_arbiter.sv
// Two-port arbiter onto a single-port synchronous RAM: grant, address/data mux, read-valid pipeline.
module mem16x10_arbiter
    import mem16x10_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    port_id_t          last_gnt_q, last_gnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              pick0, pick1;

    arb2_pick #(
        .PRIO_MODE (PRIO_MODE),
        .MAX_WAIT  (MAX_WAIT)
    ) u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .last_gnt_i (last_gnt_q),
        .wait_cnt_i (wait_cnt_q),
        .gnt0_o     (pick0),
        .gnt1_o     (pick1)
    );

    // Nothing is issued to memory while reset is held.
    assign gnt0 = rst_n & pick0;
    assign gnt1 = rst_n & pick1;

    always_comb begin
        mem_wea   = 1'b0;
        mem_addra = addr_q;
        mem_dina  = din_q;
        if (gnt0) begin
            mem_wea   = we0;
            mem_addra = addr0;
            mem_dina  = wdata0;
        end else if (gnt1) begin
            mem_wea   = we1;
            mem_addra = addr1;
            mem_dina  = wdata1;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = PORT0;
        end else if (gnt1) begin
            last_gnt_d = PORT1;
        end

        wait_cnt_d = '0;
        if (req1 && !gnt1) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q
                                                   : wait_cnt_q + WAIT_W'(1);
        end

        addr_d    = mem_addra;
        din_d     = mem_dina;
        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            last_gnt_q <= PORT1;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    // A read issued just before reset must not surface while reset is held.
    assign rvalid0 = rst_n & rvalid0_q;
    assign rvalid1 = rst_n & rvalid1_q;
    assign rdata0  = rvalid0 ? mem_douta : '0;
    assign rdata1  = rvalid1 ? mem_douta : '0;

endmodule

// File: tb/tb_mem16x10_arbiter.sv
// Bench for mem16x10_arbiter: round-robin and fixed-priority instances, each with its own RAM.
module tb_mem16x10_arbiter;

    localparam int MW = 4;

    logic clka;
    logic rst_n;
    logic req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic [1:0]       g0_w, g1_w, rv0_w, rv1_w, wea_w;
    logic [1:0][15:0] rd0_w, rd1_w, din_w, dout_w;
    logic [1:0][9:0]  addr_w;

    logic [15:0] mem_m [2][1024];
    logic [15:0] refm  [2][1024];

    int  m_last [2];
    int  m_wait [2];
    bit  m_rv0 [2];
    bit  m_rv1 [2];
    logic [15:0] m_rd0 [2];
    logic [15:0] m_rd1 [2];
    logic [9:0]  m_addr [2];
    logic [15:0] m_din [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [9:0]  a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [15:0] d1;
        logic [1:0][1:0]  eg;
        logic [1:0][1:0]  erv;
        logic [1:0][15:0] erd;
        logic        ewea;
        logic [1:0][9:0]  ea;
        logic [15:0] edin;
    } vec_t;

    vec_t tbl [$];

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    mem16x10_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MW)) u_rr (
        .clka(clka), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(g0_w[0]), .rvalid0(rv0_w[0]), .rdata0(rd0_w[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(g1_w[0]), .rvalid1(rv1_w[0]), .rdata1(rd1_w[0]),
        .mem_wea(wea_w[0]), .mem_addra(addr_w[0]), .mem_dina(din_w[0]),
        .mem_douta(dout_w[0])
    );

    mem16x10_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MW)) u_fp (
        .clka(clka), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(g0_w[1]), .rvalid0(rv0_w[1]), .rdata0(rd0_w[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(g1_w[1]), .rvalid1(rv1_w[1]), .rdata1(rd1_w[1]),
        .mem_wea(wea_w[1]), .mem_addra(addr_w[1]), .mem_dina(din_w[1]),
        .mem_douta(dout_w[1])
    );

    always @(posedge clka) begin
        for (int k = 0; k < 2; k++) begin
            if (wea_w[k]) mem_m[k][addr_w[k]] <= din_w[k];
            dout_w[k] <= mem_m[k][addr_w[k]];
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d act=%0h exp=%0h", nm, k, act, exp);
        end
    endtask

    // Which port the rules say wins this cycle: -1 none, 0, or 1. Instance k uses PRIO_MODE=k.
    function automatic int exp_grant(input int k);
        if (!rst_n) return -1;
        if (req0 && req1) begin
            if (k == 0) return (m_last[0] == 0) ? 1 : 0;
            return (m_wait[1] == MW) ? 1 : 0;
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_check(input int k);
        int g;
        logic ev0, ev1;
        g = exp_grant(k);
        ev0 = rst_n && m_rv0[k];
        ev1 = rst_n && m_rv1[k];
        chk("m_gnt0", k, 32'(g0_w[k]), 32'(g == 0));
        chk("m_gnt1", k, 32'(g1_w[k]), 32'(g == 1));
        chk("m_wea",  k, 32'(wea_w[k]), 32'((g == 0) ? we0 : (g == 1) ? we1 : 1'b0));
        chk("m_addr", k, 32'(addr_w[k]), 32'((g == 0) ? addr0 : (g == 1) ? addr1 : m_addr[k]));
        chk("m_din",  k, 32'(din_w[k]), 32'((g == 0) ? wdata0 : (g == 1) ? wdata1 : m_din[k]));
        chk("m_rv0",  k, 32'(rv0_w[k]), 32'(ev0));
        chk("m_rv1",  k, 32'(rv1_w[k]), 32'(ev1));
        chk("m_rd0",  k, 32'(rd0_w[k]), 32'(ev0 ? m_rd0[k] : 16'h0));
        chk("m_rd1",  k, 32'(rd1_w[k]), 32'(ev1 ? m_rd1[k] : 16'h0));
    endtask

    task automatic model_update(input int k);
        int g;
        g = exp_grant(k);
        if (!rst_n) begin
            m_last[k] = 1; m_wait[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
            m_addr[k] = '0; m_din[k] = '0;
        end else begin
            m_rv0[k] = (g == 0) && !we0;
            m_rv1[k] = (g == 1) && !we1;
            m_rd0[k] = refm[k][addr0];
            m_rd1[k] = refm[k][addr1];
            if (g == 0) begin
                m_last[k] = 0; m_addr[k] = addr0; m_din[k] = wdata0;
                if (we0) refm[k][addr0] = wdata0;
            end else if (g == 1) begin
                m_last[k] = 1; m_addr[k] = addr1; m_din[k] = wdata1;
                if (we1) refm[k][addr1] = wdata1;
            end
            if (req1 && g != 1) m_wait[k] = (m_wait[k] < MW) ? m_wait[k] + 1 : MW;
            else                m_wait[k] = 0;
        end
    endtask

    // Called at the falling edge: model checks, model step, then advance past the rising edge.
    task automatic eval_cycle();
        if (chk_en) for (int k = 0; k < 2; k++) model_check(k);
        for (int k = 0; k < 2; k++) model_update(k);
        if (!rst_n) chk_en = 1;
        @(posedge clka);
        #1;
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0, input logic [9:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1,
                         input logic [9:0] a1, input logic [15:0] d1);
        rst_n = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    function automatic vec_t mk(input logic rst, input logic r0, input logic w0, input logic [9:0] a0,
                                input logic [15:0] d0, input logic r1, input logic w1,
                                input logic [9:0] a1, input logic [15:0] d1,
                                input logic [1:0] eg_a, input logic [1:0] eg_b,
                                input logic [1:0] rv_a, input logic [1:0] rv_b,
                                input logic [15:0] rd_a, input logic [15:0] rd_b,
                                input logic wea, input logic [9:0] ea_a, input logic [9:0] ea_b,
                                input logic [15:0] din);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg[0] = eg_a;  v.eg[1] = eg_b;
        v.erv[0] = rv_a; v.erv[1] = rv_b;
        v.erd[0] = rd_a; v.erd[1] = rd_b;
        v.ewea = wea; v.ea[0] = ea_a; v.ea[1] = ea_b; v.edin = din;
        return v;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) begin
                mem_m[k][i] = 16'(i);
                refm[k][i]  = 16'(i);
            end

        // Columns: rst r0 w0 a0 d0 r1 w1 a1 d1 | gnt{1,0} rr,fp | rvalid{1,0} rr,fp | rdata rr,fp | wea | addr rr,fp | din
        // Both ports reading 1 and 2 continuously: rr alternates, fp starves port 1 for MW cycles.
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b01,2'b01, 2'b00,2'b00, 0,0, 0, 1,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b10,2'b01, 2'b01,2'b01, 1,1, 0, 2,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b01,2'b01, 2'b10,2'b01, 2,1, 0, 1,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b10,2'b01, 2'b01,2'b01, 1,1, 0, 2,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b01,2'b10, 2'b10,2'b01, 2,1, 0, 1,2, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b10,2'b01, 2'b01,2'b10, 1,2, 0, 2,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b01,2'b01, 2'b10,2'b01, 2,1, 0, 1,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b10,2'b01, 2'b01,2'b01, 1,1, 0, 2,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b01,2'b01, 2'b10,2'b01, 2,1, 0, 1,1, 0));
        tbl.push_back(mk(1,1,0,1,0,1,0,2,0, 2'b10,2'b10, 2'b01,2'b01, 1,1, 0, 2,2, 0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 2'b00,2'b00, 2'b10,2'b10, 2,2, 0, 2,2, 0));
        // Port 1 writes 166 to 332, port 0 reads it back next cycle.
        tbl.push_back(mk(1,0,0,0,0,1,1,332,166, 2'b10,2'b10, 2'b00,2'b00, 0,0, 1, 332,332, 166));
        tbl.push_back(mk(1,1,0,332,0,0,0,0,0,   2'b01,2'b01, 2'b00,2'b00, 0,0, 0, 332,332, 0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,     2'b00,2'b00, 2'b01,2'b01, 166,166, 0, 332,332, 0));
        // Top address, all-ones data.
        tbl.push_back(mk(1,0,0,0,0,1,1,1023,16'hFFFF, 2'b10,2'b10, 2'b00,2'b00, 0,0, 1, 1023,1023, 16'hFFFF));
        tbl.push_back(mk(1,0,0,0,0,1,0,1023,0,        2'b10,2'b10, 2'b00,2'b00, 0,0, 0, 1023,1023, 0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,           2'b00,2'b00, 2'b10,2'b10, 16'hFFFF,16'hFFFF, 0, 1023,1023, 0));
        // Reset, then a lone port-0 read of address 5.
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00, 2'b00,2'b00, 0,0, 0, 1023,1023, 0));
        tbl.push_back(mk(1,1,0,5,0,0,0,0,0, 2'b01,2'b01, 2'b00,2'b00, 0,0, 0, 5,5, 0));
        // Port 1 read, then reset with both requesting: no rvalid, no grant, port 0 first afterwards.
        tbl.push_back(mk(1,0,0,0,0,1,0,7,0,  2'b10,2'b10, 2'b01,2'b01, 5,5, 0, 7,7, 0));
        tbl.push_back(mk(0,1,0,9,0,1,0,10,0, 2'b00,2'b00, 2'b00,2'b00, 0,0, 0, 7,7, 0));
        tbl.push_back(mk(1,1,0,9,0,1,0,10,0, 2'b01,2'b01, 2'b00,2'b00, 0,0, 0, 9,9, 0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,  2'b00,2'b00, 2'b01,2'b01, 9,9, 0, 9,9, 0));

        drive(0, 0,0,0,0, 0,0,0,0);
        @(posedge clka);
        #1;
        @(negedge clka);
        eval_cycle();

        // Reset held with both ports requesting: nothing may be granted.
        drive(0, 1,0,3,16'h1234, 1,1,4,16'h5678);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", k, 32'({g1_w[k], g0_w[k]}), 32'd0);
            chk("rst_wea", k, 32'(wea_w[k]), 32'd0);
            chk("rst_addr", k, 32'(addr_w[k]), 32'd0);
            chk("rst_din", k, 32'(din_w[k]), 32'd0);
            chk("rst_rv", k, 32'({rv1_w[k], rv0_w[k]}), 32'd0);
        end
        eval_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.rst, v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
            @(negedge clka);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vec%0d_gnt", i), k, 32'({g1_w[k], g0_w[k]}), 32'(v.eg[k]));
                chk($sformatf("vec%0d_rv", i), k, 32'({rv1_w[k], rv0_w[k]}), 32'(v.erv[k]));
                chk($sformatf("vec%0d_rd0", i), k, 32'(rd0_w[k]), 32'(v.erv[k][0] ? v.erd[k] : 16'h0));
                chk($sformatf("vec%0d_rd1", i), k, 32'(rd1_w[k]), 32'(v.erv[k][1] ? v.erd[k] : 16'h0));
                chk($sformatf("vec%0d_wea", i), k, 32'(wea_w[k]), 32'(v.ewea));
                chk($sformatf("vec%0d_addr", i), k, 32'(addr_w[k]), 32'(v.ea[k]));
                chk($sformatf("vec%0d_din", i), k, 32'(din_w[k]), 32'(v.edin));
            end
            eval_cycle();
        end

        // Random traffic, addresses often confined to a small window to provoke read-after-write.
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] ra0, ra1;
            ra0 = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
            ra1 = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), ra0, 16'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom), ra1, 16'($urandom));
            @(negedge clka);
            eval_cycle();
        end

        // Port 0 writes, port 1 reads the same word the very next cycle.
        drive(1, 1,1,100,16'hBEEF, 0,0,0,0);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            chk("raw_wr_gnt", k, 32'({g1_w[k], g0_w[k]}), 32'd1);
            chk("raw_wr_wea", k, 32'(wea_w[k]), 32'd1);
            chk("raw_wr_din", k, 32'(din_w[k]), 32'hBEEF);
        end
        eval_cycle();
        drive(1, 0,0,0,0, 1,0,100,0);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            chk("raw_rd_gnt", k, 32'({g1_w[k], g0_w[k]}), 32'd2);
            chk("raw_rd_norv", k, 32'({rv1_w[k], rv0_w[k]}), 32'd0);
        end
        eval_cycle();
        drive(1, 0,0,0,0, 0,0,0,0);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            chk("raw_rv", k, 32'({rv1_w[k], rv0_w[k]}), 32'd2);
            chk("raw_rd1", k, 32'(rd1_w[k]), 32'hBEEF);
        end
        eval_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
